aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Moore FSM that sequences the 4x4 systolic PE array through one full AES-128 encryption of a single block.
- Drives the array controls: pe_en, op_sel, load_psum and shift_in_en.
- Fetches the round key for each round from the round-key store over a req/ack handshake.
- Reports busy and a one-cycle done pulse to the host-side block controller.

Parameters:
- NR, 10, number of AES rounds; legal range 1..14.
- KIDX_W, 4, width of the key_idx output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to encrypt the block currently presented on the array's data_n inputs; sampled only in IDLE.
- abort  input  1  synchronous cancel; effective in any state.
- key_ack  input  1  round-key store: the key for key_idx is stable on the array key inputs.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; the data_s outputs hold the ciphertext.
- pe_en  output  1  array enable.
- op_sel  output  2  array operation: 00 SubBytes, 01 AddRoundKey, 10 MixColumns, 11 never driven.
- load_psum  output  1  array captures data_n.
- shift_in_en  output  1  array performs ShiftRows.
- key_req  output  1  request for round key key_idx.
- key_idx  output  KIDX_W  round-key index 0..NR.
- round  output  KIDX_W  current round counter, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and round=0.
  - All outputs go to 0: busy, done, pe_en, op_sel=00, load_psum, shift_in_en, key_req, key_idx.
- Output timing:
  - All outputs decode from registered state and counter only (Moore, glitch-free).
  - No input reaches an output combinationally.
- States and outputs:
  - IDLE: all outputs 0. start=1 goes to LOAD; otherwise stay.
  - LOAD (1 cycle): pe_en=1, load_psum=1. Goes to KREQ.
  - KREQ: key_req=1, key_idx=round. Stays until key_ack=1 is sampled, then goes to ARK. With key_ack already high, KREQ lasts exactly 1 cycle.
  - ARK (1 cycle): pe_en=1, op_sel=01.
    - If round==NR, go to DONE.
    - Otherwise round<=round+1 and go to SUB.
  - SUB (1 cycle): pe_en=1, op_sel=00. Goes to SHIFT.
  - SHIFT (1 cycle): pe_en=1, shift_in_en=1, op_sel=00.
    - If round==NR, go to KREQ (the final round skips MixColumns).
    - Otherwise go to MIX.
  - MIX (1 cycle): pe_en=1, op_sel=10. Goes to KREQ.
  - DONE (1 cycle): done=1, busy=1. Goes to IDLE with round<=0.
- Only one of load_psum, shift_in_en or a nonzero op_sel is active in any cycle.
- pe_en=0 in IDLE, KREQ and DONE, so the array holds state while waiting for a key.
- Latency with key_ack tied high and NR=10:
  - Start sampled at edge 0; LOAD occupies cycle 1.
  - Round 0: KREQ/ARK at cycles 2/3.
  - Rounds 1..9: 5 cycles each, cycles 4..48.
  - Final round: SUB/SHIFT/KREQ/ARK at cycles 49..52.
  - done=1 in cycle 53; IDLE from cycle 54.
  - General formula: 3 + 5*(NR-1) + 4 + 1 = 5*NR + 3 cycles.
- Key stalls: each cycle key_ack stays low in KREQ adds one cycle. key_idx and key_req stay stable throughout the stall.
- start while busy is ignored; it is not queued.
- start in the DONE cycle is ignored; the next block can start from the IDLE cycle that follows.
- abort=1: next state is IDLE and round=0 regardless of current state or key_ack. done is not pulsed. abort has priority over every transition, including start in IDLE.
- key_ack outside KREQ is ignored.
- Reset mid-operation: immediate return to IDLE; array contents are don't-care.
- round counter saturates at NR and never wraps.

Test Plan:
- Reset with start=1 held: all outputs 0 during reset. Release rst_n → LOAD on the first edge where start is sampled, with load_psum=1, pe_en=1.
- NR=10, key_ack=1, single start pulse:
  - op_sel sequence observed on pe_en cycles: load, 01, then (00, 00+shift, 10, 01) ×9, then 00, 00+shift, 01.
  - done=1 exactly 53 cycles after start; key_idx on successive key_req cycles is 0..10.
- key_ack held low 3 cycles in round 4: KREQ lasts 4 cycles with key_idx=4 stable and pe_en=0; done arrives at cycle 56.
- abort asserted during MIX of round 5: IDLE next cycle, busy=0, round=0, no done pulse. A new start afterwards completes normally in 53 cycles.
- start pulsed while busy (cycle 20) and during the DONE cycle: both ignored; exactly one done pulse is produced.
- rst_n dropped asynchronously mid-KREQ: outputs go to 0 immediately, without a clock edge. After release, state is IDLE and busy=0.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Moore FSM stepping the 4x4 systolic PE array through one AES-128 block encryption.
// Latency 5*NR+3 cycles from start to done; stalls in KREQ while key_ack is low.
module aes_round_sequencer #(
   parameter int NR     = 10,
   parameter int KIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              key_ack,
   output logic              busy,
   output logic              done,
   output logic              pe_en,
   output logic [1:0]        op_sel,
   output logic              load_psum,
   output logic              shift_in_en,
   output logic              key_req,
   output logic [KIDX_W-1:0] key_idx,
   output logic [KIDX_W-1:0] round
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_KREQ  = 3'd2,
      S_ARK   = 3'd3,
      S_SUB   = 3'd4,
      S_SHIFT = 3'd5,
      S_MIX   = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   localparam logic [1:0] OP_SUB = 2'b00;
   localparam logic [1:0] OP_ARK = 2'b01;
   localparam logic [1:0] OP_MIX = 2'b10;

   localparam logic [KIDX_W-1:0] NR_K  = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] ONE_K = KIDX_W'(1);

   state_t            state;
   state_t            state_nxt;
   logic [KIDX_W-1:0] round_q;
   logic [KIDX_W-1:0] round_nxt;
   logic              last_round;

   assign last_round = (round_q == NR_K);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         round_q <= '0;
      end else begin
         state   <= state_nxt;
         round_q <= round_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      round_nxt = round_q;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_KREQ;
         S_KREQ:  if (key_ack) state_nxt = S_ARK;
         S_ARK: begin
            // Round advances after its key is mixed in; it saturates at NR.
            if (last_round) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_SUB;
               round_nxt = round_q + ONE_K;
            end
         end
         S_SUB:   state_nxt = S_SHIFT;
         // The final round has no MixColumns step.
         S_SHIFT: state_nxt = last_round ? S_KREQ : S_MIX;
         S_MIX:   state_nxt = S_KREQ;
         S_DONE: begin
            state_nxt = S_IDLE;
            round_nxt = '0;
         end
         default: begin
            state_nxt = S_IDLE;
            round_nxt = '0;
         end
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         round_nxt = '0;
      end
   end

   // Outputs depend only on registered state and round, never on inputs.
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      pe_en       = 1'b0;
      op_sel      = OP_SUB;
      load_psum   = 1'b0;
      shift_in_en = 1'b0;
      key_req     = 1'b0;
      key_idx     = '0;
      case (state)
         S_IDLE: ;
         S_LOAD: begin
            busy      = 1'b1;
            pe_en     = 1'b1;
            load_psum = 1'b1;
         end
         S_KREQ: begin
            busy    = 1'b1;
            key_req = 1'b1;
            key_idx = round_q;
         end
         S_ARK: begin
            busy   = 1'b1;
            pe_en  = 1'b1;
            op_sel = OP_ARK;
         end
         S_SUB: begin
            busy  = 1'b1;
            pe_en = 1'b1;
         end
         S_SHIFT: begin
            busy        = 1'b1;
            pe_en       = 1'b1;
            shift_in_en = 1'b1;
         end
         S_MIX: begin
            busy   = 1'b1;
            pe_en  = 1'b1;
            op_sel = OP_MIX;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign round = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench: expected per-cycle output traces are built from the round schedule.
module tb_aes_round_sequencer;

   localparam int NR = 10;
   localparam int KW = 4;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, key_ack;
   logic          busy, done, pe_en, load_psum, shift_in_en, key_req;
   logic [1:0]    op_sel;
   logic [KW-1:0] key_idx, round;

   aes_round_sequencer #(.NR(NR), .KIDX_W(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_ack(key_ack),
      .busy(busy), .done(done), .pe_en(pe_en), .op_sel(op_sel), .load_psum(load_psum),
      .shift_in_en(shift_in_en), .key_req(key_req), .key_idx(key_idx), .round(round)
   );

   always #5 clk = ~clk;

   // {busy, done, pe_en, op_sel, load_psum, shift_in_en, key_req, key_idx, round}
   logic [15:0] ov;
   assign ov = {busy, done, pe_en, op_sel, load_psum, shift_in_en, key_req, key_idx, round};

   typedef struct packed {
      logic        kreq;
      logic        klast;
      logic [15:0] o;
   } step_t;

   step_t trace[$];
   int    st[NR+1];
   int    checks = 0;
   int    fails  = 0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input bit b, input bit d, input bit pe, input int op,
                                      input bit ld, input bit sh, input bit kr,
                                      input int kidx, input int rnd);
      logic [1:0]    o2;
      logic [KW-1:0] k4, r4;
      o2 = op[1:0];
      k4 = kidx[KW-1:0];
      r4 = rnd[KW-1:0];
      return {b, d, pe, o2, ld, sh, kr, k4, r4};
   endfunction

   function automatic void push(input bit kreq, input bit klast, input logic [15:0] o);
      step_t s;
      s.kreq  = kreq;
      s.klast = klast;
      s.o     = o;
      trace.push_back(s);
   endfunction

   // Expected cycle-by-cycle outputs from LOAD through DONE, given per-round key stalls.
   function automatic void build_trace();
      trace.delete();
      push(0, 0, mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
      for (int r = 0; r <= NR; r++) begin
         for (int s = 0; s <= st[r]; s++)
            push(1, s == st[r], mk(1, 0, 0, 0, 0, 0, 1, r, r));
         push(0, 0, mk(1, 0, 1, 1, 0, 0, 0, 0, r));
         if (r < NR) begin
            push(0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, r + 1));
            push(0, 0, mk(1, 0, 1, 0, 0, 1, 0, 0, r + 1));
            if (r + 1 != NR) push(0, 0, mk(1, 0, 1, 2, 0, 0, 0, 0, r + 1));
         end
      end
      push(0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, NR));
   endfunction

   function automatic int total_stalls();
      int t = 0;
      for (int r = 0; r <= NR; r++) t += st[r];
      return t;
   endfunction

   // Caller sets start=1 just after a negedge; the following posedge is edge 0.
   task automatic run_txn(input int abort_at, input int rst_at);
      int   ndone = 0;
      int   done_cyc = -1;
      bit   prev_req = 0;
      int   kq[$];
      for (int i = 0; i < trace.size(); i++) begin
         @(negedge clk);
         check_eq("step", ov, trace[i].o);
         if (done) begin
            ndone++;
            done_cyc = i + 1;
         end
         if (key_req && !prev_req) kq.push_back(int'(key_idx));
         prev_req = key_req;
         key_ack = trace[i].kreq ? trace[i].klast : 1'($urandom);
         start   = (i == 19 || trace[i].o[14]) ? 1'b1 : 1'($urandom);
         if (i == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            check_eq("abort_idle", ov, 16'h0000);
            check_eq("abort_nodone", 16'(ndone), 16'd0);
            abort = 1'b0;
            start = 1'b0;
            return;
         end
         if (i == rst_at) begin
            #2 rst_n = 1'b0;
            #1 check_eq("async_rst", ov, 16'h0000);
            @(negedge clk);
            check_eq("rst_held", ov, 16'h0000);
            rst_n   = 1'b1;
            start   = 1'b0;
            key_ack = 1'b0;
            @(negedge clk);
            check_eq("rst_release_idle", ov, 16'h0000);
            return;
         end
      end
      @(negedge clk);
      check_eq("idle_after", ov, 16'h0000);
      start = 1'b0;
      check_eq("done_count", 16'(ndone), 16'd1);
      check_eq("latency", 16'(done_cyc), 16'(5 * NR + 3 + total_stalls()));
      check_eq("kidx_count", 16'(kq.size()), 16'(NR + 1));
      for (int k = 0; k < kq.size(); k++) check_eq("kidx_seq", 16'(kq[k]), 16'(k));
   endtask

   function automatic void clear_stalls();
      for (int r = 0; r <= NR; r++) st[r] = 0;
   endfunction

   function automatic void rand_stalls();
      for (int r = 0; r <= NR; r++) st[r] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
   endfunction

   function automatic int find_mix(input int rnd);
      for (int i = 0; i < trace.size(); i++)
         if (trace[i].o[12:11] == 2'b10 && int'(trace[i].o[3:0]) == rnd) return i;
      return -1;
   endfunction

   function automatic int find_kreq(input int rnd);
      for (int i = 0; i < trace.size(); i++)
         if (trace[i].kreq && int'(trace[i].o[3:0]) == rnd) return i;
      return -1;
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; key_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("in_reset", ov, 16'h0000);
      end
      rst_n = 1'b1;

      // Start held through reset: LOAD on the first edge after release.
      clear_stalls();
      build_trace();
      run_txn(-1, -1);

      // Three-cycle key stall in round 4.
      clear_stalls();
      st[4] = 3;
      build_trace();
      start = 1'b1;
      run_txn(-1, -1);

      // Abort in MIX of round 5, then a clean block.
      clear_stalls();
      build_trace();
      start = 1'b1;
      run_txn(find_mix(5), -1);
      start = 1'b1;
      run_txn(-1, -1);

      // Abort beats start in IDLE.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      check_eq("abort_idle_start", ov, 16'h0000);
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("idle_quiet", ov, 16'h0000);

      // Randomized key stalls.
      repeat (4) begin
         rand_stalls();
         build_trace();
         start = 1'b1;
         run_txn(-1, -1);
      end

      // Asynchronous reset while waiting for a key.
      rand_stalls();
      build_trace();
      start = 1'b1;
      run_txn(-1, find_kreq($urandom_range(0, NR)));

      // Abort at a random point of the block.
      rand_stalls();
      build_trace();
      start = 1'b1;
      run_txn($urandom_range(0, trace.size() - 2), -1);
      start = 1'b1;
      clear_stalls();
      build_trace();
      run_txn(-1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
